// File: rtl/instr_exec_unit.sv
// instr_exec_unit
//   Walks an inclusive, wrapping address range of an instruction register, executes each
//   instruction on its signed operands and hands one result per instruction to a
//   valid/ready write-back sink. DIV/MOD go through an iterative restoring divider.
// Ports
//   clk, reset                 clock (rising edge) and asynchronous active-high reset
//   start, first_addr, last_addr  run request and inclusive address range (start seen in IDLE only)
//   read_pointer, instruction_word  registered fetch address / combinational instruction read
//   wb_valid, wb_ready, wb_addr, wb_rezultat  write-back channel
//   busy, done, exec_count     status: not idle, end-of-run pulse, write-backs this run
//   div_by_zero, illegal_opc   sticky per-run error flags

package instr_exec_pkg;
  localparam int ADDR_W    = 5;
  localparam int OPERAND_W = 32;
  localparam int RESULT_W  = 62;

  typedef logic [ADDR_W-1:0]           address_t;
  typedef logic signed [OPERAND_W-1:0] operand_t;
  typedef logic signed [RESULT_W-1:0]  rezultat_t;

  typedef enum logic [3:0] {
    ZERO  = 4'd0,
    PASSA = 4'd1,
    PASSB = 4'd2,
    ADD   = 4'd3,
    SUB   = 4'd4,
    MULT  = 4'd5,
    DIV   = 4'd6,
    MOD   = 4'd7
  } opcode_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
  } instruction_t;
endpackage

module instr_exec_unit
  import instr_exec_pkg::*;
#(
  parameter int ADDR_WIDTH    = 5,
  parameter int OPERAND_WIDTH = 32,
  parameter int RESULT_WIDTH  = 62
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [ADDR_WIDTH-1:0]          first_addr,
  input  logic [ADDR_WIDTH-1:0]          last_addr,
  output logic [ADDR_WIDTH-1:0]          read_pointer,
  input  instruction_t                   instruction_word,
  output logic                           wb_valid,
  input  logic                           wb_ready,
  output logic [ADDR_WIDTH-1:0]          wb_addr,
  output logic signed [RESULT_WIDTH-1:0] wb_rezultat,
  output logic                           busy,
  output logic                           done,
  output logic [ADDR_WIDTH:0]            exec_count,
  output logic                           div_by_zero,
  output logic                           illegal_opc
);

  generate
    if (ADDR_WIDTH != $bits(address_t) || OPERAND_WIDTH != $bits(operand_t) ||
        RESULT_WIDTH != $bits(rezultat_t)) begin : g_width_check
      $error("instr_exec_unit parameters disagree with instr_exec_pkg types");
    end
  endgenerate

  localparam int MSB = OPERAND_WIDTH - 1;
  localparam int EXT = RESULT_WIDTH - OPERAND_WIDTH;
  localparam int CW  = $clog2(OPERAND_WIDTH);

  typedef enum logic [2:0] {IDLE, FETCH, EXEC, DIVIDE, WB} state_t;

  state_t                          state_reg;
  logic [3:0]                      opc_reg;
  logic signed [OPERAND_WIDTH-1:0] op_a_reg;
  logic signed [OPERAND_WIDTH-1:0] op_b_reg;
  logic [OPERAND_WIDTH-1:0]        rem_reg;
  logic [OPERAND_WIDTH-1:0]        quo_reg;
  logic [OPERAND_WIDTH-1:0]        dvs_reg;
  logic [CW-1:0]                   cnt_reg;
  logic                            neg_res_reg;
  logic                            is_mod_reg;

  assign busy = (state_reg != IDLE);

  // Operands are sign-extended to the result width; the low RESULT_WIDTH bits of the
  // product of the extended operands equal the low bits of the full signed product.
  logic signed [RESULT_WIDTH-1:0] a_ext, b_ext, alu_result;
  assign a_ext = {{EXT{op_a_reg[MSB]}}, op_a_reg};
  assign b_ext = {{EXT{op_b_reg[MSB]}}, op_b_reg};

  always_comb begin
    alu_result = '0;
    case (opc_reg)
      PASSA:   alu_result = a_ext;
      PASSB:   alu_result = b_ext;
      ADD:     alu_result = a_ext + b_ext;
      SUB:     alu_result = a_ext - b_ext;
      MULT:    alu_result = a_ext * b_ext;
      default: alu_result = '0;
    endcase
  end

  logic is_div, is_illegal;
  assign is_div     = (opc_reg == DIV) || (opc_reg == MOD);
  assign is_illegal = opc_reg[3];

  // Magnitudes as unsigned; -2^(W-1) maps to 2^(W-1), which still fits.
  logic [OPERAND_WIDTH-1:0] mag_a, mag_b;
  assign mag_a = op_a_reg[MSB] ? -op_a_reg : op_a_reg;
  assign mag_b = op_b_reg[MSB] ? -op_b_reg : op_b_reg;

  // One restoring step: the remainder stays below the divisor, so the shifted partial
  // remainder fits in OPERAND_WIDTH+1 bits and the borrow bit decides the quotient bit.
  logic [OPERAND_WIDTH:0]   rem_shift, diff;
  logic                     take;
  logic [OPERAND_WIDTH-1:0] rem_next, quo_next;
  assign rem_shift = {rem_reg, quo_reg[MSB]};
  assign diff      = rem_shift - {1'b0, dvs_reg};
  assign take      = ~diff[OPERAND_WIDTH];
  assign rem_next  = take ? diff[OPERAND_WIDTH-1:0] : rem_shift[OPERAND_WIDTH-1:0];
  assign quo_next  = {quo_reg[OPERAND_WIDTH-2:0], take};

  // Final step result is taken straight from the step logic so the write-back loads on
  // the OPERAND_WIDTH-th divide edge.
  logic [RESULT_WIDTH-1:0] mag_ext, div_result;
  assign mag_ext    = {{EXT{1'b0}}, (is_mod_reg ? rem_next : quo_next)};
  assign div_result = neg_res_reg ? -mag_ext : mag_ext;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      read_pointer <= '0;
      wb_valid     <= 1'b0;
      wb_addr      <= '0;
      wb_rezultat  <= '0;
      done         <= 1'b0;
      exec_count   <= '0;
      div_by_zero  <= 1'b0;
      illegal_opc  <= 1'b0;
      opc_reg      <= '0;
      op_a_reg     <= '0;
      op_b_reg     <= '0;
      rem_reg      <= '0;
      quo_reg      <= '0;
      dvs_reg      <= '0;
      cnt_reg      <= '0;
      neg_res_reg  <= 1'b0;
      is_mod_reg   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            read_pointer <= first_addr;
            exec_count   <= '0;
            div_by_zero  <= 1'b0;
            illegal_opc  <= 1'b0;
            state_reg    <= FETCH;
          end
        end
        FETCH: begin
          opc_reg   <= instruction_word.opc;
          op_a_reg  <= instruction_word.op_a;
          op_b_reg  <= instruction_word.op_b;
          state_reg <= EXEC;
        end
        EXEC: begin
          wb_addr <= read_pointer;
          if (is_div && (op_b_reg != '0)) begin
            rem_reg     <= '0;
            quo_reg     <= mag_a;
            dvs_reg     <= mag_b;
            cnt_reg     <= '0;
            is_mod_reg  <= (opc_reg == MOD);
            // Remainder follows the dividend's sign; quotient is negative on sign mismatch.
            neg_res_reg <= (opc_reg == MOD) ? op_a_reg[MSB] : (op_a_reg[MSB] ^ op_b_reg[MSB]);
            state_reg   <= DIVIDE;
          end else begin
            wb_rezultat <= is_div ? '0 : alu_result;
            wb_valid    <= 1'b1;
            if (is_div) div_by_zero <= 1'b1;
            if (is_illegal) illegal_opc <= 1'b1;
            state_reg <= WB;
          end
        end
        DIVIDE: begin
          rem_reg <= rem_next;
          quo_reg <= quo_next;
          cnt_reg <= cnt_reg + CW'(1);
          if (cnt_reg == CW'(OPERAND_WIDTH - 1)) begin
            wb_rezultat <= div_result;
            wb_valid    <= 1'b1;
            state_reg   <= WB;
          end
        end
        WB: begin
          if (wb_ready) begin
            wb_valid   <= 1'b0;
            exec_count <= exec_count + (ADDR_WIDTH + 1)'(1);
            if (read_pointer == last_addr) begin
              done      <= 1'b1;
              state_reg <= IDLE;
            end else begin
              read_pointer <= read_pointer + ADDR_WIDTH'(1);
              state_reg    <= FETCH;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
